if_id_stage: RTL and testbench

IF/ID pipeline boundary sitting directly downstream of the PC/fetch stage.
- Pairs the fetch-stage PC with the instruction word returned by instruction ROM one cycle after the address was issued, and registers the pair for the ID stage.
- Handles ID stall, branch flush and upstream fetch bubbles.
- Contains a one-entry hold buffer, so an instruction arriving during an ID stall is not lost if ROM output changes while the bus is borrowed.
- Keeps saturating issue and bubble counters for performance monitoring.

---
 rtl/if_id_stage.sv | 96 +++++++++
 tb/tb_if_id_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with a one-entry hold buffer.
//
// The instruction ROM returns data one cycle after fetch issues the address.
// This block pairs that data with its PC and registers the pair for ID. When
// ID stalls, the pair present on the first stall cycle goes into a hold
// buffer, so ROM output that changes later in the stall cannot replace it.
// After the stall, the held pair issues first. A flush turns the ID slot into
// a bubble. Issue and bubble counters saturate at all-ones.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rom_en_in, stall_if          fetch qualifiers (live pair is usable when
//                                rom_en_in=1 and stall_if=0)
//   stall_id, flush              downstream control (flush has priority)
//   if_pc, rom_read_data         live fetch pair
//   id_pc, id_inst, id_valid     registered pair sent to ID
//   hold_valid                   hold buffer is occupied
//   issue_count, bubble_count    saturating performance counters
module if_id_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en_in,
  input  logic                  stall_if,
  input  logic                  stall_id,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [DATA_WIDTH-1:0] rom_read_data,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic                  id_valid,
  output logic                  hold_valid,
  output logic [CNT_WIDTH-1:0]  issue_count,
  output logic [CNT_WIDTH-1:0]  bubble_count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  ok;
  } fetch_pair_t;

  fetch_pair_t hold_q;
  fetch_pair_t live;
  fetch_pair_t src;

  assign live = '{pc: if_pc, inst: rom_read_data, ok: rom_en_in & ~stall_if};
  assign src  = hold_valid ? hold_q : live;

  // Saturating increment: add one only when the counter is not all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc        <= '0;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      hold_valid   <= 1'b0;
      hold_q       <= '0;
      issue_count  <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      // Wrong-path slot becomes a bubble. The held pair is also wrong-path.
      id_valid     <= 1'b0;
      id_inst      <= NOP_INST;
      hold_valid   <= 1'b0;
      bubble_count <= sat_inc(bubble_count);
    end else if (stall_id) begin
      // Capture only on the first stall cycle. After that, the ROM bus may
      // carry unrelated data.
      if (!hold_valid) begin
        hold_q     <= live;
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
      if (src.ok) begin
        id_pc       <= src.pc;
        id_inst     <= src.inst;
        id_valid    <= 1'b1;
        issue_count <= sat_inc(issue_count);
      end else begin
        id_valid     <= 1'b0;
        id_inst      <= NOP_INST;
        bubble_count <= sat_inc(bubble_count);
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed steps, then randomized traffic compared
// against a queue-based reference model.
module tb_if_id_stage;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [DW-1:0] NOP = '0;

  logic          clk = 1'b0;
  logic          rst, rom_en_in, stall_if, stall_id, flush;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] rom_read_data;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic          id_valid, hold_valid;
  logic [CW-1:0] issue_count, bubble_count;

  always #5 clk = ~clk;

  if_id_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .rom_en_in(rom_en_in), .stall_if(stall_if),
    .stall_id(stall_id), .flush(flush), .if_pc(if_pc), .rom_read_data(rom_read_data),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .hold_valid(hold_valid),
    .issue_count(issue_count), .bubble_count(bubble_count)
  );

  // Reference model. It tracks what ID should see and which instruction is waiting.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
    bit            ok;
  } pair_t;

  pair_t         held[$];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_inst;
  bit            m_valid;
  int            m_issue, m_bub;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    pair_t p;
    if (rst) begin
      m_pc = '0; m_inst = NOP; m_valid = 0; held.delete(); m_issue = 0; m_bub = 0;
    end else if (flush) begin
      m_valid = 0; m_inst = NOP; held.delete();
      m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
    end else if (stall_id) begin
      if (held.size() == 0) begin
        p.pc = if_pc; p.inst = rom_read_data; p.ok = rom_en_in && !stall_if;
        held.push_back(p);
      end
    end else begin
      if (held.size() != 0) p = held.pop_front();
      else begin
        p.pc = if_pc; p.inst = rom_read_data; p.ok = rom_en_in && !stall_if;
      end
      if (p.ok) begin
        m_pc = p.pc; m_inst = p.inst; m_valid = 1;
        m_issue = (m_issue < CMAX) ? m_issue + 1 : CMAX;
      end else begin
        m_valid = 0; m_inst = NOP;
        m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
      end
    end
  endtask

  // Run one clock edge, update the model with the inputs sampled at that
  // edge, and compare all outputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("id_pc", 64'(id_pc), 64'(m_pc));
    chk("id_inst", 64'(id_inst), 64'(m_inst));
    chk("id_valid", 64'(id_valid), 64'(m_valid));
    chk("hold_valid", 64'(hold_valid), 64'(held.size() != 0));
    chk("issue_count", 64'(issue_count), 64'(m_issue));
    chk("bubble_count", 64'(bubble_count), 64'(m_bub));
  endtask

  task automatic drive(input logic [AW-1:0] pc, input logic [DW-1:0] d);
    if_pc = pc; rom_read_data = d;
  endtask

  initial begin
    rst = 1; rom_en_in = 0; stall_if = 0; stall_id = 0; flush = 0;
    if_pc = '0; rom_read_data = '0;
    #2;

    // Reset, then a two-instruction stream.
    cyc(); cyc();
    chk("rst_valid", 64'(id_valid), 0);
    chk("rst_inst", 64'(id_inst), 64'(NOP));
    chk("rst_cnt", 64'(issue_count), 0);
    rst = 0; rom_en_in = 1;
    drive(32'hBFC0_0000, 32'h2401_0001); cyc();
    chk("s0_pc", 64'(id_pc), 64'hBFC0_0000);
    chk("s0_inst", 64'(id_inst), 64'h2401_0001);
    drive(32'hBFC0_0004, 32'h2402_0002); cyc();
    chk("s1_pc", 64'(id_pc), 64'hBFC0_0004);
    chk("s1_inst", 64'(id_inst), 64'h2402_0002);
    chk("s_issue", 64'(issue_count), 2);

    // Stall capture while the ROM bus changes.
    drive(32'h100, 32'hAAAA_0001); cyc();
    drive(32'h104, 32'hAAAA_0002); stall_id = 1; cyc();
    chk("st1_hold", 64'(hold_valid), 1);
    drive(32'h108, 32'hDEAD_BEEF); cyc(); cyc();
    chk("st_pc", 64'(id_pc), 64'h100);
    chk("st_inst", 64'(id_inst), 64'hAAAA_0001);
    stall_id = 0; cyc();
    chk("rel_pc", 64'(id_pc), 64'h104);
    chk("rel_inst", 64'(id_inst), 64'hAAAA_0002);
    chk("rel_hold", 64'(hold_valid), 0);

    // Flush together with a stall while the hold buffer is full.
    drive(32'h10C, 32'h3333_0000); stall_id = 1; cyc();
    flush = 1; cyc();
    chk("fl_valid", 64'(id_valid), 0);
    chk("fl_inst", 64'(id_inst), 0);
    chk("fl_hold", 64'(hold_valid), 0);
    chk("fl_bub", 64'(bubble_count), 1);
    flush = 0; stall_id = 0; drive(32'h200, 32'h1111_2222); cyc();
    chk("fl_next_pc", 64'(id_pc), 64'h200);

    // Upstream bubbles from stall_if and from rom_en_in=0.
    drive(32'h204, 32'h5555_5555); stall_if = 1; cyc(); cyc();
    chk("ub_valid", 64'(id_valid), 0);
    chk("ub_pc", 64'(id_pc), 64'h200);
    chk("ub_bub", 64'(bubble_count), 3);
    stall_if = 0; rom_en_in = 0; cyc();
    chk("en0_bub", 64'(bubble_count), 4);
    chk("en0_pc", 64'(id_pc), 64'h200);
    rom_en_in = 1;

    // Reset while the hold buffer is full.
    stall_id = 1; cyc();
    rst = 1; cyc();
    chk("rmid_hold", 64'(hold_valid), 0);
    chk("rmid_pc", 64'(id_pc), 0);
    chk("rmid_issue", 64'(issue_count), 0);
    rst = 0; stall_id = 0; drive(32'h300, 32'h7777_0000); cyc();
    chk("rmid_next", 64'(id_pc), 64'h300);

    // Counter saturation.
    for (int i = 0; i < 40; i++) begin
      drive(32'h400 + 32'(i * 4), 32'h0C00_0000 + 32'(i)); cyc();
    end
    chk("sat_issue", 64'(issue_count), 64'(CMAX));

    // Random traffic checked against the model after each edge.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      flush     = ($urandom_range(0, 99) < 10);
      stall_id  = ($urandom_range(0, 99) < 35);
      stall_if  = ($urandom_range(0, 99) < 15);
      rom_en_in = ($urandom_range(0, 99) < 85);
      drive($urandom, $urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
